mult_seq_ctrl: RTL and testbench

//  Sequencer between the RV32 core's M-extension issue logic and the shared multi-cycle

---
 rtl/mult_seq_ctrl_if.sv | 26 ++
 rtl/mult_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_mult_seq_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mult_seq_ctrl_if.sv
// mult_seq_ctrl_if: request/response handshake and multiplier link of the M-extension sequencer
interface mult_seq_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        busy;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_start;
  logic [63:0] mul_p;
  logic        mul_done;
  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready, mul_p, mul_done,
    output req_ready, resp_valid, resp_data, resp_err, busy, mul_a, mul_b, mul_start
  );
  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready, mul_p, mul_done,
    input  req_ready, resp_valid, resp_data, resp_err, busy, mul_a, mul_b, mul_start
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequences MUL/MULH/MULHSU/MULHU onto a shared unsigned multiplier with a 1-entry product cache
module mult_seq_ctrl #(
  parameter int TIMEOUT  = 80,
  parameter bit CACHE_EN = 1'b1
) (
  input logic            clk,
  input logic            rst,
  mult_seq_ctrl_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, FIX, RESP} state_t;
  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]  op_q;
  logic [1:0]  key_q;
  logic        neg_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] mul_a_q;
  logic [31:0] mul_b_q;
  logic [31:0] resp_data_q;
  logic        resp_err_q;
  logic        cache_v_q;
  logic [31:0] cache_a_q;
  logic [31:0] cache_b_q;
  logic [1:0]  cache_key_q;
  logic [63:0] cache_p_q;
  logic        a_sgn_d;
  logic        b_sgn_d;
  logic        neg_d;
  logic        hit_d;
  logic [31:0] mag_a_d;
  logic [31:0] mag_b_d;
  logic [63:0] prod_d;
  // operand signedness, magnitudes, cache lookup and product sign fix-up
  always_comb begin
    a_sgn_d = bus.req_op != 2'b11;
    b_sgn_d = !bus.req_op[1];
    neg_d   = (a_sgn_d & bus.req_a[31]) ^ (b_sgn_d & bus.req_b[31]);
    mag_a_d = (a_sgn_d & bus.req_a[31]) ? 32'd0 - bus.req_a : bus.req_a;
    mag_b_d = (b_sgn_d & bus.req_b[31]) ? 32'd0 - bus.req_b : bus.req_b;
    hit_d   = CACHE_EN && cache_v_q && bus.req_a == cache_a_q && bus.req_b == cache_b_q &&
              (bus.req_op == 2'b00 || {a_sgn_d, b_sgn_d} == cache_key_q);
    prod_d  = neg_q ? ~bus.mul_p + 64'd1 : bus.mul_p;
  end
  // control FSM with operand, result and cache registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      key_q       <= '0;
      neg_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      cache_v_q   <= 1'b0;
      cache_a_q   <= '0;
      cache_b_q   <= '0;
      cache_key_q <= '0;
      cache_p_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          op_q  <= bus.req_op;
          key_q <= {a_sgn_d, b_sgn_d};
          neg_q <= neg_d;
          a_q   <= bus.req_a;
          b_q   <= bus.req_b;
          if (hit_d) begin
            resp_data_q <= bus.req_op == 2'b00 ? cache_p_q[31:0] : cache_p_q[63:32];
            resp_err_q  <= 1'b0;
            state_q     <= RESP;
          end else begin
            mul_a_q <= mag_a_d;
            mul_b_q <= mag_b_d;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: if (cnt_q != '0 && bus.mul_done) begin
          state_q <= FIX;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          resp_err_q  <= 1'b1;
          resp_data_q <= '0;
          cache_v_q   <= 1'b0;
          state_q     <= RESP;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        FIX: begin
          resp_data_q <= op_q == 2'b00 ? prod_d[31:0] : prod_d[63:32];
          resp_err_q  <= 1'b0;
          cache_v_q   <= CACHE_EN;
          cache_a_q   <= a_q;
          cache_b_q   <= b_q;
          cache_key_q <= key_q;
          cache_p_q   <= prod_d;
          state_q     <= RESP;
        end
        RESP: if (bus.resp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.req_ready  = state_q == IDLE;
  assign bus.busy       = state_q != IDLE;
  assign bus.resp_valid = state_q == RESP;
  assign bus.mul_start  = state_q == LOAD;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: directed and randomized checks of mult_seq_ctrl against an arithmetic reference model
module tb_mult_seq_ctrl;
  localparam int TIMEOUT = 80;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_delay = 2;
  bit   m_never = 1'b0;
  bit   m_act = 1'b0;
  int   m_left = 0;
  logic [63:0] m_p = '0;
  bit          mc_v = 1'b0;
  logic [31:0] mc_a = '0;
  logic [31:0] mc_b = '0;
  logic [1:0]  mc_key = '0;
  mult_seq_ctrl_if bus ();
  mult_seq_ctrl #(.TIMEOUT(TIMEOUT), .CACHE_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (bus.mul_start) begin
      m_act  <= 1'b1;
      m_left <= m_delay - 1;
      m_p    <= {32'd0, bus.mul_a} * {32'd0, bus.mul_b};
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
    end
  end
  assign bus.mul_done = m_act && m_left == 0 && !m_never;
  assign bus.mul_p    = m_p;

  task automatic chk_reset_vals();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $error("FAIL rst_req_ready got %0h want 1", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $error("FAIL rst_resp_valid got %0h want 0", bus.resp_valid); end
    checks++; if (bus.resp_data !== 32'd0) begin errors++; $error("FAIL rst_resp_data got %0h want 0", bus.resp_data); end
    checks++; if (bus.resp_err !== 1'b0) begin errors++; $error("FAIL rst_resp_err got %0h want 0", bus.resp_err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $error("FAIL rst_busy got %0h want 0", bus.busy); end
    checks++; if (bus.mul_start !== 1'b0) begin errors++; $error("FAIL rst_mul_start got %0h want 0", bus.mul_start); end
    checks++; if (bus.mul_a !== 32'd0) begin errors++; $error("FAIL rst_mul_a got %0h want 0", bus.mul_a); end
    checks++; if (bus.mul_b !== 32'd0) begin errors++; $error("FAIL rst_mul_b got %0h want 0", bus.mul_b); end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int dly, input bit nodone, input int hold);
    logic [63:0] ea, eb, pr;
    logic [31:0] expd, ma, mb;
    logic [1:0]  key;
    bit          as, bs, hit, to;
    int          t, s, r, starts, el;
    as   = op != 2'b11;
    bs   = op == 2'b00 || op == 2'b01;
    key  = {as, bs};
    ea   = as ? {{32{a[31]}}, a} : {32'd0, a};
    eb   = bs ? {{32{b[31]}}, b} : {32'd0, b};
    pr   = ea * eb;
    ma   = (as && a[31]) ? -a : a;
    mb   = (bs && b[31]) ? -b : b;
    hit  = mc_v && a == mc_a && b == mc_b && (op == 2'b00 || key == mc_key);
    to   = nodone && !hit;
    expd = to ? 32'd0 : (op == 2'b00 ? pr[31:0] : pr[63:32]);
    m_delay = dly;
    m_never = nodone;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $error("FAIL req_ready_idle got %0h want 1", bus.req_ready); end
    t = cyc;
    s = -1;
    r = -1;
    starts = 0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int i = 0; i < 300 && r < 0; i++) begin
      @(negedge clk);
      if (bus.mul_start) begin
        starts++;
        if (s < 0) s = cyc;
        checks++; if (bus.mul_a !== ma) begin errors++; $error("FAIL mul_a_mag got %0h want %0h", bus.mul_a, ma); end
        checks++; if (bus.mul_b !== mb) begin errors++; $error("FAIL mul_b_mag got %0h want %0h", bus.mul_b, mb); end
      end
      if (bus.resp_valid) r = cyc;
    end
    checks++; if (r < 0) begin errors++; $error("FAIL resp_seen got none want response"); end
    if (hit) begin
      checks++; if (starts != 0) begin errors++; $error("FAIL hit_no_start got %0d want 0", starts); end
      checks++; if (r != t + 1) begin errors++; $error("FAIL hit_latency got %0d want %0d", r, t + 1); end
    end else begin
      el = to ? s + TIMEOUT + 2 : s + dly + 2;
      checks++; if (starts != 1) begin errors++; $error("FAIL miss_one_start got %0d want 1", starts); end
      checks++; if (s != t + 1) begin errors++; $error("FAIL start_latency got %0d want %0d", s, t + 1); end
      checks++; if (r != el) begin errors++; $error("FAIL resp_latency got %0d want %0d", r, el); end
    end
    checks++; if (bus.resp_data !== expd) begin errors++; $error("FAIL resp_data got %0h want %0h", bus.resp_data, expd); end
    checks++; if (bus.resp_err !== to) begin errors++; $error("FAIL resp_err got %0h want %0h", bus.resp_err, to); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $error("FAIL resp_busy got %0h want 1", bus.busy); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $error("FAIL resp_req_ready got %0h want 0", bus.req_ready); end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++; if (bus.resp_valid !== 1'b1) begin errors++; $error("FAIL hold_valid got %0h want 1", bus.resp_valid); end
      checks++; if (bus.resp_data !== expd) begin errors++; $error("FAIL hold_data got %0h want %0h", bus.resp_data, expd); end
      checks++; if (bus.resp_err !== to) begin errors++; $error("FAIL hold_err got %0h want %0h", bus.resp_err, to); end
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $error("FAIL hold_req_ready got %0h want 0", bus.req_ready); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $error("FAIL hold_busy got %0h want 1", bus.busy); end
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $error("FAIL done_valid got %0h want 0", bus.resp_valid); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $error("FAIL done_req_ready got %0h want 1", bus.req_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $error("FAIL done_busy got %0h want 0", bus.busy); end
    if (to) mc_v = 1'b0;
    else if (!hit) begin
      mc_v = 1'b1;
      mc_a = a;
      mc_b = b;
      mc_key = key;
    end
  endtask

  initial begin
    logic [31:0] pool [4];
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    pool[0] = 32'h0000_0007;
    pool[1] = 32'hFFFF_FFF9;
    pool[2] = 32'h8000_0000;
    pool[3] = 32'h7FFF_FFFF;
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    #12;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b1;
    do_op(2'b00, 32'd3, 32'hFFFF_FFFB, 33, 1'b0, 0);
    do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 5, 1'b0, 0);
    do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 1'b0, 0);
    do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6, 1'b0, 1);
    do_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 10, 1'b0, 0);
    do_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 10, 1'b0, 0);
    do_op(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 12, 1'b0, 5);
    do_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 2, 1'b1, 2);
    do_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 7, 1'b0, 0);
    m_delay = 40;
    m_never = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    bus.req_a     = 32'hDEAD_BEEF;
    bus.req_b     = 32'h0BAD_F00D;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $error("FAIL pre_rst_busy got %0h want 1", bus.busy); end
    #2 rst = 1'b0;
    #1 chk_reset_vals();
    @(negedge clk);
    rst = 1'b1;
    mc_v = 1'b0;
    do_op(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D, 9, 1'b0, 0);
    do_op(2'b00, 32'hDEAD_BEEF, 32'h0BAD_F00D, 9, 1'b0, 0);
    for (int k = 0; k < 30; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 3)] : $urandom;
      rb  = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 3) == 0) begin
        ra = mc_a;
        rb = mc_b;
      end
      do_op(rop, ra, rb, $urandom_range(2, 40), 1'b0, $urandom_range(0, 3));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $error("FAIL watchdog got timeout want finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
